fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised synchronous FIFO with programmable almost-empty/almost-full thresholds, an occupancy count, a registered read port with valid strobe, and overflow/underflow error reporting. Successor to the fixed 6-bit FIFO. It sits between the producer and consumer stages of the data path. The consumer stage throttles the producer with `pause`, which is driven from almost-full.

## Interface
- `DATA_WIDTH`, 6, width of each stored word.
- `ADDR_WIDTH`, 3, pointer width; depth `DEPTH = 2**ADDR_WIDTH`.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `RESET`  input  1  synchronous, active-high reset.
- `data_in`  input  DATA_WIDTH  write data.
- `fifo_wr`  input  1  write request.
- `fifo_rd`  input  1  read request.
- `al_empty_in`  input  ADDR_WIDTH+1  almost-empty threshold.
- `al_full_in`  input  ADDR_WIDTH+1  almost-full threshold.
- `data_out`  output  DATA_WIDTH  registered read data.
- `valid_out`  output  1  `data_out` carries a word popped last cycle.
- `fifo_empty`  output  1  count == 0.
- `fifo_full`  output  1  count == DEPTH.
- `al_empty`  output  1  count <= `al_empty_in`.
- `al_full`  output  1  count >= `al_full_in`.
- `pause`  output  1  equal to `al_full`.
- `count`  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `error`  output  1  overflow/underflow indication (see Configuration).

## Operation
- Storage: DEPTH x DATA_WIDTH register array. Write pointer and read pointer are ADDR_WIDTH bits each and wrap modulo DEPTH naturally. `count` is a separate ADDR_WIDTH+1-bit register.
- Write accept: `fifo_wr & (~fifo_full | rd_accept)`. On accept, store `data_in` at the write pointer and increment the write pointer.
- Read accept (`rd_accept`): `fifo_rd & ~fifo_empty`. On accept, `data_out` <= mem[read pointer], `valid_out` <= 1, and the read pointer increments.
- If a read is not accepted: `valid_out` <= 0 and `data_out` holds its last value.
- Count update: +1 on write accept only; -1 on read accept only; unchanged when both or neither are accepted.
- Simultaneous read and write when full: both are accepted; count stays DEPTH and there is no error.
- Simultaneous read and write when empty: the write is accepted and the read is rejected as an underflow. Count becomes 1.
- Overflow: `fifo_wr` while full without an accepted read. The data is dropped and the error event fires.
- Underflow: `fifo_rd` while empty. The read is ignored and the error event fires.
- Flags are combinational from the registered `count` and the threshold inputs. Threshold inputs may change at any time; flags follow in the same cycle.
- Thresholds above DEPTH are legal:
  - `al_full_in` > DEPTH: `al_full` never asserts.
  - `al_full_in` = 0: `al_full` is always asserted.

## Timing
- Write-to-read latency: a word written at edge N can be popped at edge N+1 at the earliest. It appears on `data_out` after that edge.
- Read latency: one cycle from the accepted `fifo_rd` edge to `data_out`/`valid_out`.
- Flags and `count` reflect the post-edge state in the same cycle as the update.
- Reset values (synchronous, takes effect at the first rising edge with `RESET`=1):
  - pointers 0, `count` 0, `data_out` 0, `valid_out` 0, `error` 0.
  - `fifo_empty` 1, `fifo_full` 0, `al_empty` 1.
  - `al_full` and `pause` are 1 only if `al_full_in` == 0.
- Reset mid-operation discards all contents. Memory array contents are not cleared but become unreachable.
- Reset has priority over concurrent `fifo_wr`/`fifo_rd`.

## Configuration
- `FIFO_STICKY_ERR_EN` defined: `error` latches to 1 on the first overflow/underflow and clears only on `RESET`.
- `FIFO_STICKY_ERR_EN` undefined: `error` is a registered one-cycle pulse in the cycle after each offending request. It stays 1 for consecutive offending cycles.

## Test plan
Defaults for all scenarios: DATA_WIDTH=6, ADDR_WIDTH=3, `al_empty_in`=2, `al_full_in`=6.
- Reset, then write 6'b010010 and read the next cycle -> `data_out`=6'b010010 with `valid_out`=1 one cycle after the read. `count` goes 0->1->0; `fifo_empty` returns to 1.
- Write 8 words 0..7 back-to-back:
  - `al_empty` deasserts at count 3.
  - `al_full`/`pause` assert at count 6.
  - `fifo_full`=1 at count 8.
  - Then read 8 -> words 0..7 appear in order.
- At full, a 9th write with `fifo_rd`=0 -> word dropped, `count` stays 8, `error`=1. Sticky build: `error` holds until `RESET`. Default build: one-cycle pulse.
- At full, simultaneous write 6'b111111 and read -> oldest word is output, `count` stays 8, no error. 6'b111111 is read out last after draining.
- Read while empty together with write 6'b000101 -> `valid_out`=0, `error` event, `count`=1. The next read returns 6'b000101.
- Fill to 5, assert `RESET` for one cycle with `fifo_wr`=1 -> `count`=0, `fifo_empty`=1, `valid_out`=0. A subsequent write+read returns only the new word (pointer wrap checked across 16+ writes).

Source files
------------

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with programmable almost-empty/full thresholds,
// registered read port and overflow/underflow error. Define FIFO_STICKY_ERR_EN for a sticky error.
module fifo_param #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_wr,
  input  logic                  fifo_rd,
  input  logic [ADDR_WIDTH:0]   al_empty_in,
  input  logic [ADDR_WIDTH:0]   al_full_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  al_empty,
  output logic                  al_full,
  output logic                  pause,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  error
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic empty_c;
  logic full_c;
  logic rd_accept_c;
  logic wr_accept_c;
  logic err_event_c;

  // Status flags straight from the registered occupancy
  always_comb begin
    empty_c = (count_q == CW'(0));
    full_c  = (count_q == CW'(DEPTH));
  end

  // A pop frees a slot in the same cycle, so a write at full is accepted alongside a read
  always_comb begin
    rd_accept_c = fifo_rd & ~empty_c;
    wr_accept_c = fifo_wr & (~full_c | rd_accept_c);
    err_event_c = (fifo_wr & full_c & ~rd_accept_c) | (fifo_rd & empty_c);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    mem_d       = mem_q;
`ifdef FIFO_STICKY_ERR_EN
    error_d     = error_q | err_event_c;
`else
    error_d     = err_event_c;
`endif
    if (wr_accept_c) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rd_accept_c) begin
      data_out_d  = mem_q[rd_ptr_q];
      valid_out_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
    end
    if (wr_accept_c && !rd_accept_c) begin
      count_d = count_q + CW'(1);
    end else if (rd_accept_c && !wr_accept_c) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      error_q     <= error_d;
    end
  end

  // Storage is not reset; stale words become unreachable once the pointers clear
  always_ff @(posedge clk) begin
    if (!RESET) begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    data_out   = data_out_q;
    valid_out  = valid_out_q;
    count      = count_q;
    error      = error_q;
    fifo_empty = empty_c;
    fifo_full  = full_c;
    al_empty   = (count_q <= al_empty_in);
    al_full    = (count_q >= al_full_in);
    pause      = (count_q >= al_full_in);
  end

endmodule

// File: tb/tb_fifo_param.sv
// Randomised bench for fifo_param against a queue-based reference model.
module tb_fifo_param;

  localparam int unsigned DW    = 6;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          RESET;
  logic [DW-1:0] data_in;
  logic          fifo_wr;
  logic          fifo_rd;
  logic [AW:0]   al_empty_in;
  logic [AW:0]   al_full_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          fifo_empty;
  logic          fifo_full;
  logic          al_empty;
  logic          al_full;
  logic          pause;
  logic [AW:0]   count;
  logic          error;

  fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .RESET       (RESET),
    .data_in     (data_in),
    .fifo_wr     (fifo_wr),
    .fifo_rd     (fifo_rd),
    .al_empty_in (al_empty_in),
    .al_full_in  (al_full_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .al_empty    (al_empty),
    .al_full     (al_full),
    .pause       (pause),
    .count       (count),
    .error       (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout;
  logic          m_vld;
  logic          m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference behaviour: a plain queue with the acceptance rules applied to pre-edge state
  task automatic model_update(input logic rst, input logic wr, input logic rd, input logic [DW-1:0] din);
    int  n;
    bit  full, empty, rd_ok, wr_ok, evt;
    n     = m_q.size();
    full  = (n == DEPTH);
    empty = (n == 0);
    rd_ok = rd && !empty;
    wr_ok = wr && (!full || rd_ok);
    evt   = (wr && full && !rd_ok) || (rd && empty);
    if (rst) begin
      m_q.delete();
      m_dout = '0;
      m_vld  = 1'b0;
      m_err  = 1'b0;
    end else begin
      if (rd_ok) begin
        m_dout = m_q.pop_front();
        m_vld  = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
      if (wr_ok) m_q.push_back(din);
`ifdef FIFO_STICKY_ERR_EN
      m_err = m_err | evt;
`else
      m_err = evt;
`endif
    end
  endtask

  task automatic compare_all();
    int n;
    n = m_q.size();
    check("count",      32'(count),      32'(n));
    check("data_out",   32'(data_out),   32'(m_dout));
    check("valid_out",  32'(valid_out),  32'(m_vld));
    check("fifo_empty", 32'(fifo_empty), 32'(n == 0));
    check("fifo_full",  32'(fifo_full),  32'(n == DEPTH));
    check("al_empty",   32'(al_empty),   32'(n <= int'(al_empty_in)));
    check("al_full",    32'(al_full),    32'(n >= int'(al_full_in)));
    check("pause",      32'(pause),      32'(n >= int'(al_full_in)));
    check("error",      32'(error),      32'(m_err));
  endtask

  task automatic step(input logic rst, input logic wr, input logic rd, input logic [DW-1:0] din);
    RESET   = rst;
    fifo_wr = wr;
    fifo_rd = rd;
    data_in = din;
    @(posedge clk);
    model_update(rst, wr, rd, din);
    #1;
    compare_all();
  endtask

  initial begin
    RESET       = 1'b1;
    fifo_wr     = 1'b0;
    fifo_rd     = 1'b0;
    data_in     = '0;
    al_empty_in = 4'd2;
    al_full_in  = 4'd6;
    m_dout      = '0;
    m_vld       = 1'b0;
    m_err       = 1'b0;

    step(1'b1, 1'b0, 1'b0, '0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);

    // Single word round trip
    step(1'b0, 1'b1, 1'b0, 6'b010010);
    check("tp1_count1", 32'(count), 32'd1);
    step(1'b0, 1'b0, 1'b1, '0);
    check("tp1_data",  32'(data_out), 32'h12);
    check("tp1_valid", 32'(valid_out), 32'd1);

    // Fill 0..7 then drain in order
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, DW'(i));
    check("fill_full", 32'(fifo_full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      check("drain_order", 32'(data_out), 32'(i));
    end

    // Overflow at full, then simultaneous read/write at full
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, DW'(i + 8));
    step(1'b0, 1'b1, 1'b0, 6'h2a);
    check("ovf_err",   32'(error), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 6'b111111);
    check("rw_full_data",  32'(data_out), 32'd8);
    check("rw_full_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, '0);
    check("rw_full_last", 32'(data_out), 32'h3f);

    // Read+write while empty: write wins, read is an underflow
    step(1'b0, 1'b1, 1'b1, 6'b000101);
    check("udf_valid", 32'(valid_out), 32'd0);
    check("udf_err",   32'(error), 32'd1);
    check("udf_count", 32'(count), 32'd1);
    step(1'b0, 1'b0, 1'b1, '0);
    check("udf_data", 32'(data_out), 32'h05);

    // Reset mid-fill with a concurrent write
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, DW'(i + 20));
    step(1'b1, 1'b1, 1'b0, 6'h33);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_err",   32'(error), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0, DW'(i + 40));
      step(1'b0, 1'b0, 1'b1, '0);
      check("wrap_data", 32'(data_out), 32'(i + 40));
    end

    // Threshold corner cases
    al_full_in = 4'd0;
    #1;
    check("af_zero", 32'(al_full), 32'd1);
    al_full_in = 4'd9;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, DW'(i));
    check("af_above_depth", 32'(al_full), 32'd0);

    // Random traffic with occasional threshold changes and resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) al_empty_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) al_full_in  = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           DW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
